// File: rtl/demux16_wr_bank.sv
// demux16_wr_bank: 16-entry register bank written through a two-stage
// capture/commit pipeline, with a forwarding read port that exposes the pending write.
module demux16_wr_bank #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [3:0]            wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [3:0]            rd_sel,
  output logic [WIDTH-1:0]      rd_data,
  output logic [16*WIDTH-1:0]   q,
  output logic [15:0]           wr_onehot,
  output logic                  busy
);

  logic             s1_valid;
  logic [3:0]       s1_sel;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] bank [16];

  // Capture stage; sel/data only load on an accepted write so idle inputs never leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= wr_en & ~clr;
      if (wr_en && !clr) begin
        s1_sel  <= wr_sel;
        s1_data <= wr_data;
      end
    end
  end

  always_comb begin
    wr_onehot         = '0;
    wr_onehot[s1_sel] = s1_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (wr_onehot[i]) bank[i] <= s1_data;
      end
    end
  end

  always_comb begin
    q = '0;
    for (int i = 0; i < 16; i++) q[i*WIDTH +: WIDTH] = bank[i];
  end

  // The pending write wins over the bank so readers see it one edge before q does.
  always_comb begin
    if (s1_valid && (s1_sel == rd_sel)) rd_data = s1_data;
    else                                rd_data = bank[rd_sel];
  end

  assign busy = s1_valid;

endmodule

// File: doc/demux16_wr_bank.md
Name: demux16_wr_bank

Overview:
- Write-side counterpart of the 16:1 bit-select read mux: a 16-entry register bank written through a decoded 4:16 select, with a two-stage write pipeline (capture, then decode/commit).
- The full bank vector q drives the 16:1 read muxes directly.
- A built-in forwarding read port returns the pending write, so a reader never sees stale data during the commit cycle.
- Used for flag, valid-bit and predicate banks in the pipelined processor.

Parameters:
- WIDTH, 1, data bits per entry; WIDTH=1 gives q[15:0] for direct connection to a 16:1 mux.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of all entries and the pending write.
- wr_en  input  1  write request this cycle.
- wr_sel  input  4  entry index to write.
- wr_data  input  WIDTH  data to write.
- rd_sel  input  4  forwarding read index.
- rd_data  output  WIDTH  forwarded read data (combinational).
- q  output  16*WIDTH  bank contents; entry i is q[i*WIDTH +: WIDTH].
- wr_onehot  output  16  decoded commit strobe for the current cycle.
- busy  output  1  a write is pending commit (s1_valid).

Behaviour:
- Reset (asynchronous, active-high), applied immediately regardless of clk:
  - all q entries = 0
  - s1_valid = 0, s1_sel = 0, s1_data = 0
  - busy = 0, wr_onehot = 0, rd_data = 0
- Stage 1, capture, at each rising edge:
  - s1_valid <= wr_en & ~clr
  - if wr_en, s1_sel <= wr_sel and s1_data <= wr_data; otherwise both hold.
- Stage 2, decode: wr_onehot[i] = s1_valid & (s1_sel == i). The output is one-hot or all-zero; it is never multi-hot.
- Stage 2, commit, at each rising edge:
  - for every i with wr_onehot[i] = 1, entry i <= s1_data
  - all other entries hold.
- Latency: a write sampled at edge k is visible on q after edge k+1. busy is 1 between those two edges.
- Throughput: one write per cycle. Back-to-back writes pipeline without stalls and commit in issue order; for the same index, the last write wins.
- Forwarding read, combinational:
  - rd_data = s1_data when s1_valid & (s1_sel == rd_sel)
  - otherwise rd_data = entry rd_sel of q.
  - As a result, rd_data reflects a write one edge earlier than q does.
- clr (synchronous) at edge k:
  - all entries <= 0 and s1_valid <= 0.
  - A write pending in stage 1 is dropped, not committed.
  - A wr_en in the same cycle is ignored.
  - clr has priority over everything except reset.
- Simultaneous capture and commit to the same index: the commit uses the old s1 contents and the capture loads the new ones. Both take effect, in order.
- Reset asserted mid-write: the pending write is lost and the bank reads all zero. After release, the first write follows the normal 2-edge latency.
- No X propagation: wr_sel and wr_data are ignored when wr_en = 0.

Test Plan:
1. Reset released, wr_en=1, wr_sel=4'h5, wr_data=1 at edge 1, then wr_en=0 -> busy=1 and wr_onehot=16'h0020 after edge 1; q=16'h0020 after edge 2; busy=0 after edge 2.
2. Forwarding: after edge 1 of scenario 1 with rd_sel=5 -> rd_data=1 while q[5]=0. With rd_sel=4 -> rd_data=q[4]=0.
3. Back-to-back writes over three consecutive cycles: (sel=3, d=1), (sel=3, d=0), (sel=15, d=1) -> q sequence after edges 2, 3, 4 is 16'h0008, 16'h0000, 16'h8000.
4. All-ones fill: write every index 0..15 with 1 on consecutive cycles -> q=16'hFFFF one edge after the last write. Then clr=1 together with wr_en=1, sel=2 -> q=16'h0000 and busy=0 after that edge.
5. Pending-write flush: write sel=9, d=1, then clr on the next edge -> q[9] is never 1; q=16'h0000.
6. Asynchronous reset between edges with q=16'hA5A5 and a write pending -> q=0 and busy=0 immediately, without a clock edge. After release, write sel=0, d=1 -> q=16'h0001 two edges later.
